// File: rtl/sap1_mem_arbiter.sv
// sap1_mem_arbiter
//   Arbitrates the SAP-1 program RAM between the CPU datapath and an external
//   program loader. After reset the loader owns the RAM and the CPU is held.
//   A loader beat flagged ld_last hands the RAM to the CPU. The loader gets
//   the RAM back only after a CPU HLT followed by a new loader beat.
//
//   Optional feature: define SAP_ARB_PREEMPT_EN to let a loader beat arriving
//   while the CPU runs pre-empt it. The CPU then finishes its current
//   instruction (DRAIN) and the arbiter returns to LOAD at the next insn_end.
//
// Ports
//   clk, clrn        : clock, asynchronous active-low reset
//   cpu_addr/cpu_ce_n: CPU (MAR / control word CE) RAM request
//   insn_end         : pulse in the last T-state of each instruction
//   cpu_hlt          : CPU has executed HLT (level)
//   ld_valid/ld_addr/ld_data/ld_last : loader write beat
//   ld_ready         : loader beats are accepted
//   ram_addr/ram_wdata/ram_we/ram_ce_n : RAM port
//   cpu_hold         : freezes ring counter / PC
//   load_cnt         : beats accepted in current load (saturating at 2^ADDR_W)
module sap1_mem_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_ce_n,
  input  logic              insn_end,
  input  logic              cpu_hlt,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_ce_n,
  output logic              cpu_hold,
  output logic [ADDR_W:0]   load_cnt
);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_RUN,
    ST_DRAIN,
    ST_HALT
  } state_t;

  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t          r_state;
  state_t          w_next;
  logic [ADDR_W:0] r_load_cnt;
  logic            w_accept;
  logic            w_cnt_clr;

  // Handshake is also qualified by clrn so that no write strobe can reach
  // the RAM while reset is held, even if the loader keeps ld_valid high.
  assign ld_ready  = (r_state == ST_LOAD);
  assign cpu_hold  = (r_state == ST_LOAD) || (r_state == ST_HALT);
  assign w_accept  = ld_valid & ld_ready & clrn;
  assign ram_wdata = ld_data;
  assign load_cnt  = r_load_cnt;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state    <= ST_LOAD;
      r_load_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_cnt_clr)
        r_load_cnt <= '0;
      else if (w_accept && (r_load_cnt != CNT_MAX))
        r_load_cnt <= r_load_cnt + CNT_ONE;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_cnt_clr = 1'b0;
    ram_addr  = '0;
    ram_ce_n  = 1'b1;
    ram_we    = 1'b0;
    case (r_state)
      ST_LOAD: begin
        if (w_accept) begin
          ram_we   = 1'b1;
          ram_ce_n = 1'b0;
          ram_addr = ld_addr;
          if (ld_last)
            w_next = ST_RUN;
        end
      end
      ST_RUN: begin
        ram_addr = cpu_addr;
        ram_ce_n = cpu_ce_n;
        // HLT takes priority over a pre-empting loader beat.
        if (cpu_hlt)
          w_next = ST_HALT;
`ifdef SAP_ARB_PREEMPT_EN
        else if (ld_valid)
          w_next = ST_DRAIN;
`endif
      end
      ST_DRAIN: begin
        // CPU keeps the RAM until its current instruction completes.
        ram_addr = cpu_addr;
        ram_ce_n = cpu_ce_n;
        if (cpu_hlt || insn_end) begin
          w_next    = ST_LOAD;
          w_cnt_clr = 1'b1;
        end
      end
      ST_HALT: begin
        if (ld_valid) begin
          w_next    = ST_LOAD;
          w_cnt_clr = 1'b1;
        end
      end
      default: w_next = ST_LOAD;
    endcase
  end

endmodule

// File: tb/tb_sap1_mem_arbiter.sv
// Self-checking bench for sap1_mem_arbiter: directed scenarios plus a
// randomized run, all checked against a behavioural ownership model and a
// shadow copy of the RAM contents.
module tb_sap1_mem_arbiter;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int NWORDS = 16;

  localparam int PH_LOAD  = 0;
  localparam int PH_RUN   = 1;
  localparam int PH_DRAIN = 2;
  localparam int PH_HALT  = 3;

`ifdef SAP_ARB_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          clrn;
  logic [AW-1:0] cpu_addr;
  logic          cpu_ce_n;
  logic          insn_end;
  logic          cpu_hlt;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic          ram_ce_n;
  logic          cpu_hold;
  logic [AW:0]   load_cnt;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: who owns the RAM and what it should contain.
  int          m_phase = PH_LOAD;
  int          m_cnt   = 0;
  int          m_writes = 0;
  logic [DW-1:0] m_mem [NWORDS];

  // RAM as actually written by the DUT's strobes.
  logic [DW-1:0] d_mem [NWORDS];
  int            d_writes = 0;

  sap1_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .clrn(clrn), .cpu_addr(cpu_addr), .cpu_ce_n(cpu_ce_n),
    .insn_end(insn_end), .cpu_hlt(cpu_hlt), .ld_valid(ld_valid),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_ce_n(ram_ce_n), .cpu_hold(cpu_hold),
    .load_cnt(load_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) begin
      d_mem[ram_addr] <= ram_wdata;
      d_writes <= d_writes + 1;
    end
  end

  task automatic idle();
    ld_valid = 1'b0; ld_last = 1'b0; ld_addr = '0; ld_data = '0;
    cpu_hlt = 1'b0; insn_end = 1'b0; cpu_ce_n = 1'b1; cpu_addr = '0;
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic tick();
    int nph;
    int ncnt;
    nph  = m_phase;
    ncnt = m_cnt;
    if (ld_valid && m_phase == PH_LOAD) begin
      m_mem[ld_addr] = ld_data;
      m_writes++;
      if (ncnt < NWORDS) ncnt++;
      if (ld_last) nph = PH_RUN;
    end
    if (m_phase == PH_RUN) begin
      if (cpu_hlt) nph = PH_HALT;
      else if (PREEMPT && ld_valid) nph = PH_DRAIN;
    end else if (m_phase == PH_DRAIN) begin
      if (cpu_hlt || insn_end) begin nph = PH_LOAD; ncnt = 0; end
    end else if (m_phase == PH_HALT) begin
      if (ld_valid) begin nph = PH_LOAD; ncnt = 0; end
    end
    @(posedge clk);
    m_phase = nph;
    m_cnt   = ncnt;
    #1;
  endtask

  task automatic apply_reset();
    clrn = 1'b0;
    m_phase = PH_LOAD;
    m_cnt   = 0;
    #3;
    clrn = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    clrn = 1'b0;
    #1;
    checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL reset_hold got=%0b exp=1", cpu_hold); end
    checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", ld_ready); end
    checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%0b exp=0", ram_we); end
    checks++; if (ram_ce_n !== 1'b1) begin failures++; $display("FAIL reset_ce_n got=%0b exp=1", ram_ce_n); end
    checks++; if (ram_addr !== 4'd0) begin failures++; $display("FAIL reset_addr got=%0h exp=0", ram_addr); end
    checks++; if (load_cnt !== 5'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", load_cnt); end
    repeat (2) @(posedge clk);
    #1;
    clrn = 1'b1;
    m_phase = PH_LOAD;
    m_cnt = 0;
  endtask

  task automatic test_full_load();
    int w0;
    int bad;
    w0 = d_writes;
    for (int i = 0; i < NWORDS; i++) begin
      ld_valid = 1'b1; ld_addr = AW'(i); ld_data = DW'(8'h10 + i); ld_last = (i == NWORDS - 1);
      #1;
      checks++;
      if (ram_we !== 1'b1 || ram_ce_n !== 1'b0 || ram_addr !== AW'(i) || ram_wdata !== DW'(8'h10 + i) || cpu_hold !== 1'b1)
      begin failures++; $display("FAIL load_beat%0d got we=%0b ce_n=%0b addr=%0h wd=%0h hold=%0b exp 1 0 %0h %0h 1", i, ram_we, ram_ce_n, ram_addr, ram_wdata, cpu_hold, i, 8'h10 + i); end
      tick();
    end
    idle();
    #1;
    checks++; if (d_writes - w0 !== 16) begin failures++; $display("FAIL load_pulses got=%0d exp=16", d_writes - w0); end
    checks++; if (load_cnt !== 5'd16) begin failures++; $display("FAIL load_cnt got=%0d exp=16", load_cnt); end
    checks++; if (cpu_hold !== 1'b0 || ld_ready !== 1'b0) begin failures++; $display("FAIL load_to_run got hold=%0b ready=%0b exp 0 0", cpu_hold, ld_ready); end
    bad = 0;
    for (int i = 0; i < NWORDS; i++) if (d_mem[i] !== DW'(8'h10 + i)) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL load_contents got %0d bad words exp 0", bad); end
  endtask

  task automatic test_run_access();
    cpu_addr = 4'd5; cpu_ce_n = 1'b0;
    #1;
    checks++;
    if (ram_addr !== 4'd5 || ram_ce_n !== 1'b0 || ram_we !== 1'b0 || ld_ready !== 1'b0 || cpu_hold !== 1'b0)
    begin failures++; $display("FAIL run_access got addr=%0h ce_n=%0b we=%0b ready=%0b hold=%0b exp 5 0 0 0 0", ram_addr, ram_ce_n, ram_we, ld_ready, cpu_hold); end
    tick();
    cpu_ce_n = 1'b1;
  endtask

  task automatic test_preempt();
    int w0;
    w0 = d_writes;
    cpu_addr = 4'd2; cpu_ce_n = 1'b0;
    ld_valid = 1'b1; ld_addr = 4'd9; ld_data = 8'hEE; ld_last = 1'b0;
    #1;
    checks++; if (ram_we !== 1'b0 || cpu_hold !== 1'b0) begin failures++; $display("FAIL preempt_req got we=%0b hold=%0b exp 0 0", ram_we, cpu_hold); end
    tick();
    ld_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      insn_end = (k == 4);
      #1;
      checks++; if (cpu_hold !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 4'd2) begin failures++; $display("FAIL preempt_drain%0d got hold=%0b we=%0b addr=%0h exp 0 0 2", k, cpu_hold, ram_we, ram_addr); end
      tick();
    end
    idle();
    #1;
`ifdef SAP_ARB_PREEMPT_EN
    checks++; if (cpu_hold !== 1'b1 || ld_ready !== 1'b1) begin failures++; $display("FAIL preempt_load got hold=%0b ready=%0b exp 1 1", cpu_hold, ld_ready); end
    checks++; if (load_cnt !== 5'd0) begin failures++; $display("FAIL preempt_cnt got=%0d exp=0", load_cnt); end
    ld_valid = 1'b1; ld_addr = 4'd9; ld_data = 8'hEE; ld_last = 1'b1;
    tick();
    idle();
    #1;
    checks++; if (cpu_hold !== 1'b0 || d_mem[9] !== 8'hEE) begin failures++; $display("FAIL preempt_reload got hold=%0b mem9=%0h exp 0 ee", cpu_hold, d_mem[9]); end
`else
    checks++; if (cpu_hold !== 1'b0 || ld_ready !== 1'b0) begin failures++; $display("FAIL nopreempt_run got hold=%0b ready=%0b exp 0 0", cpu_hold, ld_ready); end
    checks++; if (d_writes != w0 || load_cnt !== 5'd16) begin failures++; $display("FAIL nopreempt_writes got writes=%0d cnt=%0d exp 0 16", d_writes - w0, load_cnt); end
`endif
  endtask

  task automatic test_halt_reload();
    cpu_hlt = 1'b1;
    #1;
    checks++; if (cpu_hold !== 1'b0) begin failures++; $display("FAIL halt_req got hold=%0b exp 0", cpu_hold); end
    tick();
    #1;
    checks++; if (cpu_hold !== 1'b1 || ld_ready !== 1'b0 || ram_ce_n !== 1'b1) begin failures++; $display("FAIL halt_state got hold=%0b ready=%0b ce_n=%0b exp 1 0 1", cpu_hold, ld_ready, ram_ce_n); end
    ld_valid = 1'b1; ld_addr = 4'd3; ld_data = 8'hA5; ld_last = 1'b1;
    #1;
    checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL halt_no_write got we=%0b exp 0", ram_we); end
    tick();
    cpu_hlt = 1'b0;
    #1;
    checks++; if (ram_we !== 1'b1 || ram_addr !== 4'd3 || ld_ready !== 1'b1 || load_cnt !== 5'd0) begin failures++; $display("FAIL halt_reload_beat got we=%0b addr=%0h ready=%0b cnt=%0d exp 1 3 1 0", ram_we, ram_addr, ld_ready, load_cnt); end
    tick();
    idle();
    #1;
    checks++; if (cpu_hold !== 1'b0 || d_mem[3] !== 8'hA5 || load_cnt !== 5'd1) begin failures++; $display("FAIL halt_reload_run got hold=%0b mem3=%0h cnt=%0d exp 0 a5 1", cpu_hold, d_mem[3], load_cnt); end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      ld_valid = 1'b1; ld_addr = AW'(i % NWORDS); ld_data = DW'($urandom); ld_last = 1'b0;
      tick();
    end
    #1;
    checks++; if (load_cnt !== 5'd16 || cpu_hold !== 1'b1) begin failures++; $display("FAIL sat_cnt got cnt=%0d hold=%0b exp 16 1", load_cnt, cpu_hold); end
    ld_last = 1'b1;
    tick();
    idle();
    #1;
    checks++; if (load_cnt !== 5'd16 || cpu_hold !== 1'b0) begin failures++; $display("FAIL sat_last got cnt=%0d hold=%0b exp 16 0", load_cnt, cpu_hold); end
  endtask

  task automatic test_reset_midload();
    int bad;
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      ld_valid = 1'b1; ld_addr = AW'(i); ld_data = DW'(8'h60 + i); ld_last = 1'b0;
      tick();
    end
    #1;
    checks++; if (load_cnt !== 5'd7) begin failures++; $display("FAIL midload_cnt got=%0d exp=7", load_cnt); end
    idle();
    clrn = 1'b0;
    m_phase = PH_LOAD;
    m_cnt = 0;
    #1;
    checks++;
    if (cpu_hold !== 1'b1 || ld_ready !== 1'b1 || ram_we !== 1'b0 || ram_ce_n !== 1'b1 || ram_addr !== 4'd0 || load_cnt !== 5'd0)
    begin failures++; $display("FAIL midload_reset got hold=%0b ready=%0b we=%0b ce_n=%0b addr=%0h cnt=%0d exp 1 1 0 1 0 0", cpu_hold, ld_ready, ram_we, ram_ce_n, ram_addr, load_cnt); end
    @(posedge clk);
    #1;
    clrn = 1'b1;
    bad = 0;
    for (int i = 0; i < 7; i++) if (d_mem[i] !== DW'(8'h60 + i)) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL midload_contents got %0d bad words exp 0", bad); end
    ld_valid = 1'b1; ld_addr = 4'd7; ld_data = 8'h67;
    tick();
    idle();
    #1;
    checks++; if (load_cnt !== 5'd1 || ld_ready !== 1'b1) begin failures++; $display("FAIL midload_resume got cnt=%0d ready=%0b exp 1 1", load_cnt, ld_ready); end
  endtask

  task automatic test_random();
    logic          e_hold, e_ready, e_we, e_ce_n, acc, cpu_own;
    logic [AW-1:0] e_addr;
    logic [AW:0]   e_cnt;
    int bad;
    apply_reset();
    for (int n = 0; n < 600; n++) begin
      ld_valid = ($urandom_range(0, 1) == 1);
      ld_last  = ($urandom_range(0, 7) == 0);
      ld_addr  = AW'($urandom);
      ld_data  = DW'($urandom);
      cpu_hlt  = ($urandom_range(0, 15) == 0);
      insn_end = ($urandom_range(0, 3) == 0);
      cpu_addr = AW'($urandom);
      cpu_ce_n = ($urandom_range(0, 1) == 1);
      #1;
      e_hold  = (m_phase == PH_LOAD) || (m_phase == PH_HALT);
      e_ready = (m_phase == PH_LOAD);
      cpu_own = (m_phase == PH_RUN) || (m_phase == PH_DRAIN);
      acc     = ld_valid && e_ready;
      e_we    = acc;
      e_ce_n  = acc ? 1'b0 : (cpu_own ? cpu_ce_n : 1'b1);
      e_addr  = acc ? ld_addr : (cpu_own ? cpu_addr : '0);
      e_cnt   = (AW+1)'(m_cnt);
      checks++;
      if ({cpu_hold, ld_ready, ram_we, ram_ce_n, ram_addr, ram_wdata, load_cnt} !== {e_hold, e_ready, e_we, e_ce_n, e_addr, ld_data, e_cnt})
      begin failures++; $display("FAIL rand_cyc%0d got hold=%0b ready=%0b we=%0b ce_n=%0b addr=%0h cnt=%0d exp %0b %0b %0b %0b %0h %0d", n, cpu_hold, ld_ready, ram_we, ram_ce_n, ram_addr, load_cnt, e_hold, e_ready, e_we, e_ce_n, e_addr, e_cnt); end
      tick();
    end
    idle();
    #1;
    bad = 0;
    for (int i = 0; i < NWORDS; i++) if (d_mem[i] !== m_mem[i]) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL rand_contents got %0d bad words exp 0", bad); end
    checks++; if (d_writes != m_writes) begin failures++; $display("FAIL rand_writes got=%0d exp=%0d", d_writes, m_writes); end
  endtask

  initial begin
    for (int i = 0; i < NWORDS; i++) begin
      m_mem[i] = '0;
      d_mem[i] = '0;
    end
    clrn = 1'b0;
    idle();
    test_reset();
    test_full_load();
    test_run_access();
    test_preempt();
    test_halt_reload();
    test_saturation();
    test_reset_midload();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sap1_mem_arbiter.md
# sap1_mem_arbiter

Shares the SAP-1 16×8 program RAM between the CPU datapath and an external program loader. After reset the loader owns the RAM and the CPU is held; on loader completion the CPU runs, and (optionally) the loader may pre-empt the CPU at an instruction boundary. The block sits between the controller/MAR and `ram_top`, driving the RAM address/enable mux and a hold line that freezes the T-state ring counter.

## Interface
- `ADDR_W`, default 4, RAM address width.
- `DATA_W`, default 8, RAM data width.
- `clk` in 1: single clock; all state updates on rising edge.
- `clrn` in 1: reset, asynchronous, active-low.
- `cpu_addr` in ADDR_W: MAR output.
- `cpu_ce_n` in 1: CPU RAM enable (control word CE, active-low).
- `insn_end` in 1: one-cycle pulse in the last T-state of every instruction.
- `cpu_hlt` in 1: CPU executed HLT (level).
- `ld_valid` in 1: loader write beat valid.
- `ld_addr` in ADDR_W: loader write address.
- `ld_data` in DATA_W: loader write data.
- `ld_last` in 1: qualifies the final beat of a load.
- `ld_ready` out 1: arbiter accepts loader beats.
- `ram_addr` out ADDR_W: muxed RAM address.
- `ram_wdata` out DATA_W: RAM write data (`ld_data`).
- `ram_we` out 1: RAM write strobe.
- `ram_ce_n` out 1: muxed RAM enable, active-low.
- `cpu_hold` out 1: freezes ring counter/PC.
- `load_cnt` out ADDR_W+1: beats accepted in current load, saturating.

## Operation
- States: LOAD, RUN, DRAIN, HALT.
- Reset → LOAD. Reset values: `cpu_hold`=1, `ld_ready`=1, `ram_we`=0, `ram_ce_n`=1, `ram_addr`=0, `load_cnt`=0.
- Beat accepted when `ld_valid & ld_ready`; in that cycle `ram_we`=1, `ram_ce_n`=0, `ram_addr`=`ld_addr`. `load_cnt` +1, saturating at 2^ADDR_W.
- LOAD: `cpu_hold`=1, `ld_ready`=1. Accepted beat with `ld_last` → RUN next cycle (that beat's write completes). `ld_last` without `ld_valid` ignored.
- RUN: `cpu_hold`=0, `ld_ready`=0, `ram_addr`=`cpu_addr`, `ram_ce_n`=`cpu_ce_n`, `ram_we`=0. `cpu_hlt` → HALT. `ld_valid` → DRAIN (only if preemption is compiled in; otherwise ignored).
- DRAIN: CPU keeps RAM ownership, `cpu_hold`=0; on `insn_end` → LOAD with `load_cnt` cleared. `cpu_hlt` in DRAIN → LOAD directly.
- HALT: `cpu_hold`=1, `ld_ready`=0; `ld_valid` → LOAD, `load_cnt` cleared.
- Simultaneous `cpu_hlt` and `insn_end` in DRAIN: HLT wins (→ LOAD). Simultaneous `cpu_hlt` and `ld_valid` in RUN: → HALT.
- Duplicate writes to the same address: last beat wins; no address checking.

## Timing
- Write latency: zero — RAM samples write on the edge that completes the handshake.
- `ld_ready`, `cpu_hold` are registered state decodes; change one cycle after the transition condition.
- RUN→DRAIN: 1 cycle after `ld_valid`. DRAIN→LOAD: `cpu_hold`=1 and `ld_ready`=1 on the cycle after `insn_end`; CPU never frozen mid-instruction.
- LOAD→RUN: `cpu_hold` deasserts the cycle after the `ld_last` beat.
- `clrn` low mid-load or mid-run: immediate return to reset values; partially loaded RAM contents untouched.

## Configuration
- `SAP_ARB_PREEMPT_EN` defined: RUN→DRAIN→LOAD preemption path present.
- Undefined: `ld_valid` ignored in RUN; loader regains RAM only via HALT or reset; DRAIN state unreachable.

## Test plan
- Reset, load 16 beats addr 0..15 data 0x10..0x1F, `ld_last` on beat 15 → 16 `ram_we` pulses, `load_cnt`=16, `cpu_hold`=0 one cycle later.
- RUN with `cpu_addr`=5, `cpu_ce_n`=0 → `ram_addr`=5, `ram_ce_n`=0, `ram_we`=0, `ld_ready`=0.
- Preempt (macro on): `ld_valid` in RUN, `insn_end` 4 cycles later → `cpu_hold` stays 0 for those cycles, rises the cycle after `insn_end`; `load_cnt`=0.
- Macro off: same stimulus → state remains RUN, no writes.
- `cpu_hlt` in RUN → HALT, `cpu_hold`=1; `ld_valid` → LOAD, beat addr 3 data 0xA5 with `ld_last` → write then RUN.
- `clrn` pulsed low mid-load after 7 beats → outputs at reset values immediately, `load_cnt`=0, state LOAD.
